// File: rtl/dmem_arbiter_ctrl.sv
// dmem_arbiter_ctrl: two-way round-robin arbiter and access sequencer for the
// byte-addressed little-endian data memory. Handles byte/half/word sizing,
// sign/zero extension on loads, read-modify-write for sub-word stores and
// misalignment/reserved-size error reporting. One transaction in flight.
module dmem_arbiter_ctrl #(
  parameter int DW    = 32,
  parameter int ADDRW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [1:0]         we,
  input  logic [3:0]         size,
  input  logic [1:0]         uns,
  input  logic [2*ADDRW-1:0] addr,
  input  logic [2*DW-1:0]    wdata,
  output logic [1:0]         gnt,
  output logic [1:0]         rvalid,
  output logic [DW-1:0]      rdata,
  output logic               err,
  output logic [ADDRW-1:0]   mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [DW-1:0]      mem_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCESS = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] RMW_WR = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]       state;
  logic             prio;      // requester favoured when both request
  logic             owner;
  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [ADDRW-1:0] addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    merge_q;

  logic             win;
  logic             sel_we;
  logic [1:0]       sel_size;
  logic             sel_uns;
  logic [ADDRW-1:0] sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic             sel_bad;

  // Misaligned halves/words and the reserved size code never touch memory.
  function automatic logic bad_access(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'b11) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
  endfunction

  // Pick the addressed lane(s) out of the memory word and extend to DW bits.
  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] word,
                                             input logic [1:0] sz,
                                             input logic [1:0] a,
                                             input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    logic [DW-1:0] res;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: res = {{(DW-8){b[7] & ~u}}, b};
      SZ_HALF: res = {{(DW-16){h[15] & ~u}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of the old word with the store data.
  function automatic logic [DW-1:0] merge_store(input logic [DW-1:0] old,
                                                input logic [1:0] sz,
                                                input logic [1:0] a,
                                                input logic [DW-1:0] wd);
    logic [DW-1:0] res;
    res = old;
    case (sz)
      SZ_BYTE: res[{a, 3'b000} +: 8]     = wd[7:0];
      SZ_HALF: res[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: res = wd;
    endcase
    return res;
  endfunction

  // Winner selection and payload mux; gnt only pulses in IDLE and out of reset.
  always_comb begin
    win       = (req == 2'b11) ? prio : req[1];
    sel_we    = win ? we[1]  : we[0];
    sel_size  = win ? size[3:2] : size[1:0];
    sel_uns   = win ? uns[1] : uns[0];
    sel_addr  = win ? addr[2*ADDRW-1:ADDRW] : addr[ADDRW-1:0];
    sel_wdata = win ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    sel_bad   = bad_access(sel_size, sel_addr[1:0]);
    gnt       = 2'b00;
    if (state == IDLE && rst && (|req))
      gnt = win ? 2'b10 : 2'b01;
  end

  // Memory-side strobes, address and write word, decoded from the state.
  always_comb begin
    rvalid    = 2'b00;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ACCESS: begin
        mem_addr  = {addr_q[ADDRW-1:2], 2'b00};
        mem_re    = ~we_q;
        mem_we    = we_q;
        mem_wdata = we_q ? wdata_q : '0;
      end
      RMW_RD: begin
        mem_addr = {addr_q[ADDRW-1:2], 2'b00};
        mem_re   = 1'b1;
      end
      RMW_WR: begin
        mem_addr  = {addr_q[ADDRW-1:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = merge_store(merge_q, size_q, addr_q[1:0], wdata_q);
      end
      DONE:    rvalid = owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // Sequencer: latch the winner's request, walk the access, publish the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prio    <= 1'b0;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner   <= win;
            we_q    <= sel_we;
            size_q  <= sel_size;
            uns_q   <= sel_uns;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            if (sel_bad) begin
              rdata <= '0;
              err   <= 1'b1;
              state <= DONE;
            end else if (sel_we && sel_size != SZ_WORD) begin
              state <= RMW_RD;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          rdata <= we_q ? '0 : load_ext(mem_rdata, size_q, addr_q[1:0], uns_q);
          err   <= 1'b0;
          state <= DONE;
        end
        RMW_RD: begin
          merge_q <= mem_rdata;
          state   <= RMW_WR;
        end
        RMW_WR: begin
          rdata <= '0;
          err   <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          prio  <= ~owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
